// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-addressed data memory with byte enables.
// One access in flight; returns extended load data or a single error flag.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err_align,
    output logic        err_range,
    output logic        err_timeout,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ea_q, ea_d, er_q, er_d, et_q, et_d;

    logic          align_err, range_err;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, load_ext;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    always_comb begin
        align_err = 1'b0;
        case (req_size)
            2'b01:   align_err = req_addr[0];
            2'b10:   align_err = |req_addr[1:0];
            2'b11:   align_err = 1'b1;
            default: align_err = 1'b0;
        endcase
    end
    assign range_err = req_addr[31:2] >= 30'(MEM_WORDS);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{sgn_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        rdata_d = rdata_q;
        ea_d    = ea_q;
        er_d    = er_q;
        et_d    = et_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // alignment wins, so err_range is only raised on aligned accesses
                    if (align_err || range_err) begin
                        state_d = RESP;
                        rdata_d = '0;
                        ea_d    = align_err;
                        er_d    = ~align_err;
                        et_d    = 1'b0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) flush_d = 1'b1;
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : load_ext;
                    ea_d    = 1'b0;
                    er_d    = 1'b0;
                    et_d    = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    ea_d    = 1'b0;
                    er_d    = 1'b0;
                    et_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                flush_d = 1'b0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            rdata_q <= '0;
            ea_q    <= 1'b0;
            er_q    <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            rdata_q <= rdata_d;
            ea_q    <= ea_d;
            er_q    <= er_d;
            et_q    <= et_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign stall_out   = (state_q == REQ) || ((state_q == IDLE) && req_valid && !flush);
    assign resp_valid  = (state_q == RESP) && !flush_q;
    assign resp_rdata  = rdata_q;
    assign err_align   = ea_q;
    assign err_range   = er_q;
    assign err_timeout = et_q;
    assign mem_req     = (state_q == REQ);
    assign mem_we      = mem_req & we_q;
    assign mem_addr    = mem_req ? addr_q[31:2] : '0;
    assign mem_be      = mem_req ? be : '0;
    assign mem_wdata   = mem_req ? wdata_rep : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random accesses checked
// against an arithmetic model of byte-lane addressing and extension.
module tb_mem_access_unit;
    localparam int unsigned MEM_WORDS = 10;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, flush = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        req_ready, resp_valid, err_align, err_range, err_timeout, stall_out;
    logic        mem_req, mem_we;
    logic [31:0] resp_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err_align(err_align),
        .err_range(err_range), .err_timeout(err_timeout), .stall_out(stall_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MEM_WORDS];
    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic        hung;
        int          req_cycles;
        int          resp_cycle;
        int          stall_cycles;
        logic [31:0] rdata;
        logic        ea, er, et;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        unstable;
    } obs_t;

    // Expected behaviour from the access rules, using byte counts and offsets.
    function automatic void model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] word, output logic ea, output logic er,
                                  output logic [3:0] be, output logic [31:0] wrep,
                                  output logic [31:0] rd, output logic [31:0] new_word);
        int unsigned nbytes;
        int unsigned off;
        longint      v;
        nbytes = (sz == 2'd3) ? 1 : (1 << sz);
        off    = a % 4;
        ea     = (sz == 2'd3) || ((off % nbytes) != 0);
        er     = !ea && ((a / 4) >= MEM_WORDS);
        be     = 4'(((1 << nbytes) - 1) << off);
        for (int unsigned i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        v = (longint'(word) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
        if (sg && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
        rd = (we || ea || er) ? 32'd0 : 32'(v);
        new_word = word;
        for (int unsigned i = 0; i < 4; i++)
            if (we && be[i]) new_word[8*i +: 8] = wrep[8*i +: 8];
    endfunction

    // Presents one access and plays the memory; ack comes after ack_dly extra REQ cycles.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_dly, input int flush_at, output obs_t o);
        logic done;
        int   idx;
        o = '{default: 0};
        o.resp_cycle = -1;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (k == 0) begin
                req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
                req_addr = a; req_wdata = wd;
            end else begin
                req_valid = 1'b0; req_we = 1'($urandom_range(1, 0));
                req_size = 2'($urandom_range(3, 0)); req_signed = 1'($urandom_range(1, 0));
                req_addr = $urandom; req_wdata = $urandom;
            end
            flush = (k == flush_at);
            @(negedge clk);
            if (k > 0 && req_ready) begin
                done = 1'b1;
                break;
            end
            if (stall_out) o.stall_cycles++;
            if (mem_req) begin
                if (o.req_cycles == 0) begin
                    o.we = mem_we; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr || mem_be !== o.be ||
                             mem_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                mem_rdata = $urandom;
                if (o.req_cycles == ack_dly) begin
                    mem_ack = 1'b1;
                    idx = int'(mem_addr);
                    if (idx < int'(MEM_WORDS)) begin
                        if (mem_we) begin
                            for (int b = 0; b < 4; b++)
                                if (mem_be[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                        end else begin
                            mem_rdata = mem[idx];
                        end
                    end
                end
                o.req_cycles++;
            end else begin
                mem_ack   = 1'($urandom_range(1, 0));
                mem_rdata = $urandom;
            end
            if (resp_valid) begin
                o.resp_cycle = k;
                o.rdata = resp_rdata; o.ea = err_align; o.er = err_range; o.et = err_timeout;
            end
        end
        mem_ack = 1'b0;
        flush   = 1'b0;
        o.hung  = !done;
    endtask

    task automatic test_reset();
        #2;
        if ({req_ready, resp_valid, mem_req, stall_out} !== 4'b1000)
            $display("FAIL reset_ctrl: got %b want 1000", {req_ready, resp_valid, mem_req, stall_out});
        else pass_cnt++;
        total++;
        if ({resp_rdata, err_align, err_range, err_timeout, mem_we, mem_be, mem_wdata, mem_addr} !== '0)
            $display("FAIL reset_data: got rdata %h be %b wdata %h addr %h", resp_rdata, mem_be, mem_wdata, mem_addr);
        else pass_cnt++;
        total++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word_load();
        obs_t o;
        mem[2] = 32'h3;
        run_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, -1, o);
        if (o.hung) $display("FAIL wl_hung: got hung want idle"); else pass_cnt++;
        total++;
        if ({o.addr, o.be} !== {30'd2, 4'b1111}) $display("FAIL wl_mem: got addr %0d be %b want 2 1111", o.addr, o.be); else pass_cnt++;
        total++;
        if (o.resp_cycle !== 2) $display("FAIL wl_latency: got %0d want 2", o.resp_cycle); else pass_cnt++;
        total++;
        if (o.rdata !== 32'h3) $display("FAIL wl_rdata: got %h want 00000003", o.rdata); else pass_cnt++;
        total++;
        if (o.stall_cycles !== 2) $display("FAIL wl_stall: got %0d want 2", o.stall_cycles); else pass_cnt++;
        total++;
    endtask

    task automatic test_byte_load();
        obs_t o;
        mem[1] = 32'h0000_80FF;
        run_access(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 0, -1, o);
        if (o.be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", o.be); else pass_cnt++;
        total++;
        if (o.rdata !== 32'hFFFF_FF80) $display("FAIL sb_rdata: got %h want ffffff80", o.rdata); else pass_cnt++;
        total++;
        run_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1, -1, o);
        if (o.rdata !== 32'h0000_0080) $display("FAIL ub_rdata: got %h want 00000080", o.rdata); else pass_cnt++;
        total++;
    endtask

    task automatic test_half_store();
        obs_t o;
        mem[1] = 32'h1122_3344;
        run_access(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_ABCD, 0, -1, o);
        if ({o.we, o.be} !== 5'b1_1100) $display("FAIL hs_we_be: got %b want 11100", {o.we, o.be}); else pass_cnt++;
        total++;
        if (o.wdata !== 32'hABCD_ABCD) $display("FAIL hs_wdata: got %h want abcdabcd", o.wdata); else pass_cnt++;
        total++;
        if (o.rdata !== 32'h0 || o.resp_cycle !== 2) $display("FAIL hs_resp: got %h @%0d want 0 @2", o.rdata, o.resp_cycle); else pass_cnt++;
        total++;
        if (mem[1] !== 32'hABCD_3344) $display("FAIL hs_memory: got %h want abcd3344", mem[1]); else pass_cnt++;
        total++;
    endtask

    task automatic test_errors();
        obs_t o;
        run_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, -1, o);
        if ({o.ea, o.er, o.et} !== 3'b100 || o.req_cycles !== 0 || o.resp_cycle !== 1)
            $display("FAIL align_err: got flags %b req %0d resp@%0d want 100 0 1", {o.ea, o.er, o.et}, o.req_cycles, o.resp_cycle);
        else pass_cnt++;
        total++;
        run_access(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 0, -1, o);
        if ({o.ea, o.er, o.et} !== 3'b010 || o.req_cycles !== 0 || o.resp_cycle !== 1)
            $display("FAIL range_err: got flags %b req %0d resp@%0d want 010 0 1", {o.ea, o.er, o.et}, o.req_cycles, o.resp_cycle);
        else pass_cnt++;
        total++;
        run_access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, -1, o);
        if ({o.ea, o.er} !== 2'b10 || o.rdata !== 32'h0)
            $display("FAIL size11_prio: got flags %b rdata %h want 10 0", {o.ea, o.er}, o.rdata);
        else pass_cnt++;
        total++;
        run_access(1'b1, 2'b01, 1'b0, 32'h24, 32'h0, 0, -1, o);
        if ({o.ea, o.er, o.req_cycles} !== {2'b00, 32'd1} || o.resp_cycle !== 2)
            $display("FAIL last_word_ok: got flags %b req %0d want 00 1", {o.ea, o.er}, o.req_cycles);
        else pass_cnt++;
        total++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1000, -1, o);
        if (o.req_cycles !== 16 || o.resp_cycle !== 17)
            $display("FAIL to_len: got req %0d resp@%0d want 16 17", o.req_cycles, o.resp_cycle);
        else pass_cnt++;
        total++;
        if ({o.ea, o.er, o.et} !== 3'b001 || o.rdata !== 32'h0)
            $display("FAIL to_flags: got %b rdata %h want 001 0", {o.ea, o.er, o.et}, o.rdata);
        else pass_cnt++;
        total++;
        mem[3] = 32'hCAFE_0123;
        run_access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 3, -1, o);
        if (o.rdata !== 32'hCAFE_0123 || o.et !== 1'b0 || o.resp_cycle !== 5)
            $display("FAIL to_after: got %h et %b @%0d want cafe0123 0 5", o.rdata, o.et, o.resp_cycle);
        else pass_cnt++;
        total++;
        run_access(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 15, -1, o);
        if (o.rdata !== 32'hCAFE_0123 || o.et !== 1'b0 || o.req_cycles !== 16)
            $display("FAIL ack_last_cycle: got %h et %b req %0d want cafe0123 0 16", o.rdata, o.et, o.req_cycles);
        else pass_cnt++;
        total++;
    endtask

    task automatic test_flush();
        obs_t o;
        mem[4] = 32'h5555_5555;
        run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1, o);
        if (o.hung || o.resp_cycle !== -1 || o.req_cycles !== 3)
            $display("FAIL flush_resp: got hung %b resp@%0d req %0d want 0 -1 3", o.hung, o.resp_cycle, o.req_cycles);
        else pass_cnt++;
        total++;
        if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL flush_store: got %h want deadbeef", mem[4]); else pass_cnt++;
        total++;
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, -1, o);
        if (o.resp_cycle !== 2 || o.rdata !== 32'hDEAD_BEEF)
            $display("FAIL flush_clear: got %h @%0d want deadbeef 2", o.rdata, o.resp_cycle);
        else pass_cnt++;
        total++;
        @(posedge clk); #1;
        req_valid = 1'b1; flush = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
        @(negedge clk);
        if (stall_out !== 1'b0) $display("FAIL idle_flush_stall: got %b want 0", stall_out); else pass_cnt++;
        total++;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        if ({req_ready, mem_req, resp_valid} !== 3'b100)
            $display("FAIL idle_flush_drop: got %b want 100", {req_ready, mem_req, resp_valid});
        else pass_cnt++;
        total++;
    endtask

    task automatic test_reset_mid_req();
        int resp_seen;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h4; flush = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        if (mem_req !== 1'b1) $display("FAIL rst_pre: got mem_req %b want 1", mem_req); else pass_cnt++;
        total++;
        #1 reset = 1'b1;
        #1;
        if ({mem_req, req_ready} !== 2'b01) $display("FAIL rst_async: got %b want 01", {mem_req, req_ready}); else pass_cnt++;
        total++;
        @(posedge clk); #1;
        reset = 1'b0;
        resp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid || mem_req) resp_seen++;
        end
        if (resp_seen !== 0) $display("FAIL rst_no_resp: got %0d active cycles want 0", resp_seen); else pass_cnt++;
        total++;
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we, sg, ea, er;
        logic [1:0]  sz;
        logic [31:0] a, wd, old, wrep, rd, nw;
        logic [3:0]  be;
        int          idx, dly, fl, exp_req, exp_resp, exp_stall;
        logic        timeout, flushed;
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom_range(1, 0));
            sg  = 1'($urandom_range(1, 0));
            sz  = 2'($urandom_range(3, 0));
            idx = int'($urandom_range(MEM_WORDS + 1, 0));
            a   = 32'(idx * 4 + int'($urandom_range(3, 0)));
            wd  = $urandom;
            dly = ($urandom_range(9, 0) == 0) ? 20 : int'($urandom_range(4, 0));
            fl  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : -1;
            old = (idx < int'(MEM_WORDS)) ? mem[idx] : 32'h0;
            model(we, sz, sg, a, wd, old, ea, er, be, wrep, rd, nw);
            timeout   = !(ea || er) && (dly >= int'(TIMEOUT));
            exp_req   = (ea || er) ? 0 : (timeout ? int'(TIMEOUT) : dly + 1);
            flushed   = (fl >= 1) && (fl <= exp_req);
            exp_resp  = flushed ? -1 : exp_req + 1;
            exp_stall = 1 + exp_req;
            run_access(we, sz, sg, a, wd, dly, fl, o);
            if (o.hung || o.resp_cycle !== exp_resp || o.req_cycles !== exp_req || o.stall_cycles !== exp_stall)
                $display("FAIL rnd_timing[%0d]: got resp@%0d req %0d stall %0d want %0d %0d %0d", n,
                         o.resp_cycle, o.req_cycles, o.stall_cycles, exp_resp, exp_req, exp_stall);
            else pass_cnt++;
            total++;
            if (!flushed) begin
                if ({o.ea, o.er, o.et} !== {ea, er, timeout} || o.rdata !== (timeout ? 32'h0 : rd))
                    $display("FAIL rnd_resp[%0d]: got flags %b rdata %h want %b %h", n,
                             {o.ea, o.er, o.et}, o.rdata, {ea, er, timeout}, timeout ? 32'h0 : rd);
                else pass_cnt++;
                total++;
            end
            if (exp_req > 0) begin
                if (o.unstable || o.we !== we || o.addr !== a[31:2] || o.be !== be || o.wdata !== wrep)
                    $display("FAIL rnd_mem[%0d]: got we %b addr %h be %b wdata %h want %b %h %b %h", n,
                             o.we, o.addr, o.be, o.wdata, we, a[31:2], be, wrep);
                else pass_cnt++;
                total++;
                if (mem[idx] !== (timeout ? old : nw))
                    $display("FAIL rnd_word[%0d]: got %h want %h", n, mem[idx], timeout ? old : nw);
                else pass_cnt++;
                total++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_errors();
        test_timeout();
        test_flush();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface for the pipelined CPU's MEM stage.
- Accepts one load/store at a time from the pipeline and drives the word-addressed data memory with byte enables.
- Waits for the memory acknowledge, then returns sign- or zero-extended load data to the pipeline.
- Stalls the pipeline while a transaction is outstanding and flags misaligned, out-of-range and timed-out accesses.

Parameters:
- MEM_WORDS, 10, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before aborting with err_timeout. Must be >= 2.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  1  pipeline presents an access.
- req_ready  output  1  unit can accept an access.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  sign-extend load data when 1.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- flush  input  1  pipeline squash.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data (0 for stores and errors).
- err_align  output  1  misaligned or illegal size; valid with resp_valid.
- err_range  output  1  word index out of range; valid with resp_valid.
- err_timeout  output  1  no mem_ack within TIMEOUT_CYCLES; valid with resp_valid.
- stall_out  output  1  hold upstream pipeline.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  write strobe.
- mem_addr  output  30  word index, req_addr[31:2].
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  memory read word.
- mem_ack  input  1  memory completed the access; may assert in the first mem_req cycle.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready = 1. Timeout counter 0, flush latch 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & ~flush: capture all req_* fields.
    - If an error is detected, go to RESP with the matching error flag set.
    - Otherwise go to REQ.
  - Error detection: err_align if size 11, half with addr[0] = 1, or word with addr[1:0] != 0. err_range if addr[31:2] >= MEM_WORDS. Alignment takes priority; only one error flag is set per response.
  - On req_valid & flush: the request is dropped and the FSM stays in IDLE.
- REQ:
  - Drive mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are driven from the captured registers and held stable until ack.
  - mem_be: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
  - mem_wdata: byte replicated x4; half replicated x2; word as-is.
  - Timeout counter increments each REQ cycle.
  - mem_ack sampled high:
    - Drop mem_req the next cycle.
    - For loads, register the extracted lane from mem_rdata (byte lane addr[1:0], half lane addr[1]), extended per req_signed. Word loads are passed through unchanged.
    - Go to RESP.
  - Counter reaching TIMEOUT_CYCLES with no ack: drop mem_req, set err_timeout, go to RESP.
  - flush in REQ is latched. The memory transaction still completes, since store side effects are irreversible.
- RESP:
  - resp_valid = 1 for exactly one cycle, unless the flush latch is set, in which case it is suppressed.
  - Always return to IDLE. Clear the flush latch and counter.
  - resp_rdata and error flags hold their values until the next RESP.
- req_ready = 1 only in IDLE.
- stall_out = (state==REQ) | (state==IDLE & req_valid & ~flush). It is low in RESP so the pipeline advances with the result.
- mem_ack outside REQ is ignored.
- Reset mid-REQ: mem_req drops immediately (async) and no response is produced.
- Latency: an accept in cycle N with ack in cycle N+1 gives resp_valid in cycle N+2. Error accesses give resp_valid in cycle N+1 with no mem_req.

Test Plan:
- Word load at addr 0x8, memory word 2 = 3, ack in the first REQ cycle. Required: mem_addr = 2, mem_be = 1111, resp_valid after 2 cycles, resp_rdata = 0x00000003, stall_out high for 2 cycles.
- Signed byte load at addr 0x5, mem_rdata = 0x0000_80FF. Required: mem_be = 0010, resp_rdata = 0xFFFFFF80. Repeat with req_signed = 0: resp_rdata = 0x00000080.
- Half store at addr 0x6 with wdata 0x1234ABCD. Required: mem_we = 1, mem_be = 1100, mem_wdata = 0xABCDABCD, resp_rdata = 0.
- Word load at addr 0x2. Required: err_align with no mem_req. Word load at addr 0x28 (index 10). Required: err_range with no mem_req. Each gives resp_valid one cycle after accept.
- Hold mem_ack low. Required: mem_req high for exactly 16 cycles, then resp_valid with err_timeout = 1. Then issue a second load with ack delayed 3 cycles. Required: correct data returned and the counter restarted from 0.
- Assert flush during REQ with ack 2 cycles later. Required: the store completes at the memory, no resp_valid, FSM returns to IDLE. Assert reset mid-REQ. Required: mem_req = 0, req_ready = 1 immediately.
